// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle RV32I shift unit (SLL/SRL/SRA).
// One 1-bit shift stage plus a down-counter replaces a full barrel shifter;
// an operation with shift amount N returns its result N+1 edges after accept.
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   start_valid_i   request present
//   start_ready_o   unit can accept a request this cycle
//   op_i            00=SLL, 01=SRL, 10=SRA, 11=reserved (runs as SRL)
//   operand_i       value to shift
//   shamt_i         shift amount, 0..XLEN-1
//   result_valid_o  result available
//   result_ready_i  consumer takes the result
//   result_o        shifted value (driven straight from the data register)
//   busy_o          high whenever the unit is not idle
module iter_shifter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_valid_i,
    output logic               start_ready_o,
    input  logic [1:0]         op_i,
    input  logic [XLEN-1:0]    operand_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [XLEN-1:0]    result_o,
    output logic               busy_o
);

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSra = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    data_q, data_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic               accept;
    logic [XLEN-1:0]    data_shifted;

    // DONE can hand off its result and take a new request on the same edge.
    assign start_ready_o  = (state_q == StIdle) | ((state_q == StDone) & result_ready_i);
    assign accept         = start_valid_i & start_ready_o;
    assign result_valid_o = (state_q == StDone);
    assign busy_o         = (state_q != StIdle);
    assign result_o       = data_q;

    // Single 1-bit shift stage; the SRA fill bit is the current MSB, which
    // never changes during an arithmetic right shift.
    always_comb begin
        data_shifted = data_q;
        case (op_q)
            OpSll:   data_shifted = {data_q[XLEN-2:0], 1'b0};
            OpSra:   data_shifted = {data_q[XLEN-1], data_q[XLEN-1:1]};
            default: data_shifted = {1'b0, data_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        op_d    = op_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    data_d  = operand_i;
                    count_d = shamt_i;
                    op_d    = op_i;
                    state_d = StShift;
                end
            end
            StShift: begin
                // Zero check comes before the decrement, so count never wraps.
                if (count_q == '0) begin
                    state_d = StDone;
                end else begin
                    data_d  = data_shifted;
                    count_d = count_q - SHAMT_W'(1);
                end
            end
            StDone: begin
                if (result_ready_i) begin
                    if (start_valid_i) begin
                        data_d  = operand_i;
                        count_d = shamt_i;
                        op_d    = op_i;
                        state_d = StShift;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            data_q  <= '0;
            count_q <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: each task drives one scenario and checks
// its own expected values inline.
module tb_iter_shifter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_valid_i;
    logic        start_ready_o;
    logic [1:0]  op_i;
    logic [31:0] operand_i;
    logic [4:0]  shamt_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    iter_shifter #(
        .XLEN    (32),
        .SHAMT_W (5)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_valid_i  (start_valid_i),
        .start_ready_o  (start_ready_o),
        .op_i           (op_i),
        .operand_i      (operand_i),
        .shamt_i        (shamt_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one rising edge; leave the bench 1 ns after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request for one edge (assumed accepted from IDLE), then count
    // edges until result_valid rises, bounded at 64.
    task automatic run_op(input logic [1:0] op, input logic [31:0] opnd,
                          input logic [4:0] sh, output int lat);
        op_i          = op;
        operand_i     = opnd;
        shamt_i       = sh;
        start_valid_i = 1'b1;
        tick();
        start_valid_i = 1'b0;
        lat = 0;
        while (result_valid_o !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #3;
        n_cmp++;
        if (result_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result: got %h want %h", result_o, 32'h0);
        end
        n_cmp++;
        if ({result_valid_o, busy_o, start_ready_o} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_flags: got v/b/r=%b want 001",
                     {result_valid_o, busy_o, start_ready_o});
        end
        tick();
        tick();
        #2 rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_sll_max();
        int lat;
        logic bad_busy;
        logic bad_rdy;
        bad_busy = 1'b0;
        bad_rdy  = 1'b0;
        op_i          = 2'b00;
        operand_i     = 32'h0000_0001;
        shamt_i       = 5'd31;
        start_valid_i = 1'b1;
        tick();
        start_valid_i = 1'b0;
        lat = 0;
        while (result_valid_o !== 1'b1 && lat < 64) begin
            if (busy_o !== 1'b1) bad_busy = 1'b1;
            if (start_ready_o !== 1'b0) bad_rdy = 1'b1;
            tick();
            lat++;
        end
        n_cmp++;
        if (lat != 32) begin
            n_fail++;
            $display("FAIL sll31_latency: got %0d want 32", lat);
        end
        n_cmp++;
        if (result_o !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL sll31_result: got %h want 80000000", result_o);
        end
        n_cmp++;
        if (bad_busy || bad_rdy) begin
            n_fail++;
            $display("FAIL sll31_shift_flags: got busy_drop=%b ready_high=%b want 0 0",
                     bad_busy, bad_rdy);
        end
        consume();
        n_cmp++;
        if ({result_valid_o, busy_o, start_ready_o} !== 3'b001) begin
            n_fail++;
            $display("FAIL sll31_back_idle: got v/b/r=%b want 001",
                     {result_valid_o, busy_o, start_ready_o});
        end
    endtask

    task automatic test_right_shifts();
        int lat;
        run_op(2'b10, 32'h8000_0000, 5'd4, lat);
        n_cmp++;
        if (lat != 5 || result_o !== 32'hF800_0000) begin
            n_fail++;
            $display("FAIL sra4: got lat=%0d res=%h want lat=5 res=f8000000", lat, result_o);
        end
        consume();
        run_op(2'b01, 32'h8000_0000, 5'd4, lat);
        n_cmp++;
        if (lat != 5 || result_o !== 32'h0800_0000) begin
            n_fail++;
            $display("FAIL srl4: got lat=%0d res=%h want lat=5 res=08000000", lat, result_o);
        end
        consume();
        run_op(2'b11, 32'h8000_0000, 5'd4, lat);
        n_cmp++;
        if (lat != 5 || result_o !== 32'h0800_0000) begin
            n_fail++;
            $display("FAIL op11_as_srl: got lat=%0d res=%h want lat=5 res=08000000",
                     lat, result_o);
        end
        consume();
        run_op(2'b10, 32'h4000_0010, 5'd4, lat);
        n_cmp++;
        if (result_o !== 32'h0400_0001) begin
            n_fail++;
            $display("FAIL sra_positive: got %h want 04000001", result_o);
        end
        consume();
    endtask

    task automatic test_shamt_zero();
        int lat;
        run_op(2'b00, 32'hDEAD_BEEF, 5'd0, lat);
        n_cmp++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL shamt0_latency: got %0d want 1", lat);
        end
        n_cmp++;
        if (result_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL shamt0_result: got %h want deadbeef", result_o);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        logic unstable;
        unstable = 1'b0;
        op_i          = 2'b00;
        operand_i     = 32'h1234_5678;
        shamt_i       = 5'd3;
        start_valid_i = 1'b1;
        tick();
        start_valid_i = 1'b0;
        // Inputs change after accept and must be ignored.
        operand_i = 32'hFFFF_FFFF;
        shamt_i   = 5'd17;
        op_i      = 2'b10;
        lat = 0;
        while (result_valid_o !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat != 4 || result_o !== 32'h91A2_B3C0) begin
            n_fail++;
            $display("FAIL bp_result: got lat=%0d res=%h want lat=4 res=91a2b3c0", lat, result_o);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            if (result_o !== 32'h91A2_B3C0 || result_valid_o !== 1'b1 ||
                start_ready_o !== 1'b0) unstable = 1'b1;
        end
        n_cmp++;
        if (unstable) begin
            n_fail++;
            $display("FAIL bp_stall_hold: got res=%h v=%b rdy=%b want 91a2b3c0 1 0",
                     result_o, result_valid_o, start_ready_o);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(2'b00, 32'h0000_0001, 5'd2, lat);
        n_cmp++;
        if (result_o !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL b2b_first: got %h want 00000004", result_o);
        end
        result_ready_i = 1'b1;
        start_valid_i  = 1'b1;
        op_i           = 2'b01;
        operand_i      = 32'h0000_00F0;
        shamt_i        = 5'd4;
        #1;
        n_cmp++;
        if (start_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_comb: got %b want 1", start_ready_o);
        end
        tick();
        start_valid_i  = 1'b0;
        result_ready_i = 1'b0;
        n_cmp++;
        if ({busy_o, result_valid_o} !== 2'b10 || result_o !== 32'h0000_00F0) begin
            n_fail++;
            $display("FAIL b2b_no_bubble: got b/v=%b res=%h want 10 000000f0",
                     {busy_o, result_valid_o}, result_o);
        end
        lat = 0;
        while (result_valid_o !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat != 5 || result_o !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL b2b_second: got lat=%0d res=%h want lat=5 res=0000000f", lat, result_o);
        end
        consume();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        op_i          = 2'b00;
        operand_i     = 32'h0000_0001;
        shamt_i       = 5'd20;
        start_valid_i = 1'b1;
        tick();
        start_valid_i = 1'b0;
        tick();
        tick();
        tick();
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (result_o !== 32'h0 || result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: got res=%h v=%b b=%b want 0 0 0",
                     result_o, result_valid_o, busy_o);
        end
        #2 rst_ni = 1'b1;
        tick();
        run_op(2'b01, 32'h0000_0100, 5'd8, lat);
        n_cmp++;
        if (lat != 9 || result_o !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL post_reset_srl: got lat=%0d res=%h want lat=9 res=00000001",
                     lat, result_o);
        end
        consume();
    endtask

    initial begin
        rst_ni         = 1'b0;
        start_valid_i  = 1'b0;
        result_ready_i = 1'b0;
        op_i           = 2'b00;
        operand_i      = 32'h0;
        shamt_i        = 5'd0;
        test_reset();
        test_sll_max();
        test_right_shifts();
        test_shamt_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
Multi-cycle RV32I shift unit for the RV523 core ALU. It replaces a 5-level barrel shifter with one 1-bit shift stage plus a down-counter, to cut the discrete-cell count when mapped onto the RV523 gate library (NAND/NOR/AOI/OAI cells plus flip-flops). The ALU sequencer issues SLL/SRL/SRA operations over a valid/ready handshake. The result returns over a second valid/ready handshake to the writeback mux.

Parameters:
- XLEN, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request present.
- start_ready  out  1  unit can accept a request this cycle.
- op  in  2  00=SLL, 01=SRL, 10=SRA, 11=reserved (executes as SRL).
- operand  in  XLEN  value to shift.
- shamt  in  SHAMT_W  shift amount, 0..XLEN-1.
- result_valid  out  1  result is available.
- result_ready  in  1  consumer takes the result.
- result  out  XLEN  shifted value.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state=IDLE and clears data, count and op registers.
  - Outputs under reset: result=0, result_valid=0, busy=0, start_ready=1.
  - A reset mid-operation aborts the operation; no result is produced.
- States: IDLE, SHIFT, DONE.
- start_ready = (state==IDLE) | (state==DONE & result_ready).
- Accept: on an edge with start_valid & start_ready:
  - latch operand into the data register, shamt into the count register, op into the op register;
  - go to SHIFT.
- Inputs are sampled only at accept. Changes to operand, shamt or op after accept are ignored.
- SHIFT, each edge:
  - if count==0, go to DONE with data unchanged;
  - else shift data by 1 bit and decrement count.
- Shift rules:
  - SLL: data = {data[XLEN-2:0], 0}.
  - SRL: data = {0, data[XLEN-1:1]}.
  - SRA: data = {data[XLEN-1], data[XLEN-1:1]}; the sign bit is taken from the current data MSB, which equals the original operand MSB.
- Latency:
  - Let the accept edge be edge 0. DONE is entered at edge shamt+1.
  - result_valid is high from that edge until the result handshake.
  - Range: 1 edge (shamt=0) to 32 edges (shamt=31).
- DONE:
  - result_valid=1; result is held stable while result_ready=0, with no limit on stall length.
  - On an edge with result_ready=1 and start_valid=0: go to IDLE.
  - On an edge with result_ready=1 and start_valid=1: the result handshake and a new accept happen together; load the new request and go to SHIFT. No bubble.
- result is driven directly from the data register. While result_valid=0 its value is intermediate, deterministic, and not to be consumed.
- result_valid and busy are decoded registered state, with no combinational path from inputs.
- start_ready depends combinationally on result_ready. This is the only input-to-output combinational path.
- count width is SHAMT_W. Count never underflows because the count==0 check precedes the decrement.

Test Plan:
- Reset, then SLL operand=0x00000001 shamt=31 -> result_valid rises exactly 32 edges after accept; result=0x80000000; busy high throughout; start_ready low during SHIFT.
- SRA operand=0x80000000 shamt=4 -> result=0xF8000000 after 5 edges; then SRL with the same operand and shamt -> 0x08000000; then op=11 with the same operand and shamt -> 0x08000000.
- shamt=0, SLL operand=0xDEADBEEF -> result_valid one edge after accept, result=0xDEADBEEF.
- Backpressure: hold result_ready=0 for 7 cycles in DONE -> result and result_valid stable; start_ready=0. Toggling operand, shamt and op mid-SHIFT has no effect on result.
- Back-to-back: in DONE, assert result_ready=1 and start_valid=1 (SRL operand=0x000000F0 shamt=4) -> first result consumed, new op accepted on the same edge, second result=0x0000000F after 5 edges; no IDLE cycle in between.
- Reset mid-op: deassert rst_n asynchronously 3 cycles into SLL shamt=20 -> result=0, result_valid=0, busy=0 immediately. After release, a new SRL operand=0x00000100 shamt=8 returns 0x00000001.
